// File: rtl/prbs_link_ctrl.sv
// rtl/prbs_link_ctrl.sv - PRBS7 loopback link-test sequencer for the gt0_rxusrclk2_i domain
// Brings up the PRBS7 generator and dataExtract aligner, waits for lock with retries, then counts bit errors.
module prbs_link_ctrl #(
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned MAX_TRIES    = 4,
    parameter int unsigned TEST_WORDS   = 1 << 20,
    parameter int unsigned ERR_LIMIT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        gt_ready,
    input  logic        aligned,
    input  logic [5:0]  errorCount,
    output logic        prbs_dis,
    output logic        aligner_reset,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] err_total,
    output logic [3:0]  tries
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GT,
        S_ALIGN_RST,
        S_WAIT_LOCK,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] WORD_LAST  = 32'(TEST_WORDS - 1);
    localparam logic [31:0] ERR_MAX_OK = 32'(ERR_LIMIT);
    localparam logic [3:0]  TRY_MAX    = 4'(MAX_TRIES);

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [1:0] ST_LOCK = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] err_d;
    logic [3:0]  tries_d;
    logic [1:0]  status_d;
    logic        busy_d, done_d;
    logic        prbs_dis_d, aligner_reset_d;
    logic        retry;
    logic [32:0] sum_wide;
    logic [31:0] sum_sat;

    // One shared counter serves the reset pulse, the lock timeout and the word window.
    assign sum_wide = {1'b0, err_total} + {27'd0, errorCount};
    assign sum_sat  = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_total;
        tries_d  = tries;
        status_d = status;
        busy_d   = busy;
        done_d   = done;
        retry    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WAIT_GT;
                    err_d    = '0;
                    tries_d  = '0;
                    status_d = ST_NONE;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            S_WAIT_GT: begin
                // Every entry to ALIGN_RST, including after a gt_ready drop, spends a try.
                if (gt_ready) begin
                    retry = 1'b1;
                end
            end
            S_ALIGN_RST: begin
                if (!gt_ready) begin
                    state_d = S_WAIT_GT;
                end else if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (!gt_ready) begin
                    state_d = S_WAIT_GT;
                end else if (aligned) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    err_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    retry = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                if (!gt_ready) begin
                    state_d = S_WAIT_GT;
                end else if (!aligned) begin
                    retry = 1'b1;
                end else begin
                    err_d = sum_sat;
                    if (cnt_q == WORD_LAST) begin
                        state_d  = S_DONE;
                        status_d = (sum_sat <= ERR_MAX_OK) ? ST_PASS : ST_ERR;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retry) begin
            if (tries < TRY_MAX) begin
                state_d = S_ALIGN_RST;
                cnt_d   = '0;
                tries_d = tries + 4'd1;
            end else begin
                state_d  = S_DONE;
                status_d = ST_LOCK;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end
        end

        // Link-side controls follow the state being entered so they stay registered.
        prbs_dis_d      = !(state_d == S_ALIGN_RST || state_d == S_WAIT_LOCK || state_d == S_RUN);
        aligner_reset_d = !(state_d == S_WAIT_LOCK || state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            prbs_dis      <= 1'b1;
            aligner_reset <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            status        <= ST_NONE;
            err_total     <= '0;
            tries         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prbs_dis      <= prbs_dis_d;
            aligner_reset <= aligner_reset_d;
            busy          <= busy_d;
            done          <= done_d;
            status        <= status_d;
            err_total     <= err_d;
            tries         <= tries_d;
        end
    end

endmodule

// File: tb/tb_prbs_link_ctrl.sv
// tb/tb_prbs_link_ctrl.sv - self-checking bench for prbs_link_ctrl
module tb_prbs_link_ctrl;

    localparam int RSTC = 4;
    localparam int LTO  = 8;
    localparam int MT   = 2;
    localparam int TW   = 16;
    localparam int EL   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        gt_ready;
    logic        aligned;
    logic [5:0]  errorCount;
    logic        prbs_dis;
    logic        aligner_reset;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [31:0] err_total;
    logic [3:0]  tries;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] err;
        logic [3:0]  tries;
    } exp_t;

    exp_t sb[$];

    prbs_link_ctrl #(
        .RST_CYCLES  (RSTC),
        .LOCK_TIMEOUT(LTO),
        .MAX_TRIES   (MT),
        .TEST_WORDS  (TW),
        .ERR_LIMIT   (EL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .gt_ready     (gt_ready),
        .aligned      (aligned),
        .errorCount   (errorCount),
        .prbs_dis     (prbs_dis),
        .aligner_reset(aligner_reset),
        .busy         (busy),
        .done         (done),
        .status       (status),
        .err_total    (err_total),
        .tries        (tries)
    );

    always #5 clk = ~clk;

    function automatic exp_t expect_run(input logic [15:0] mask, input logic [5:0] val, input logic [3:0] t);
        exp_t e;
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < TW; i++) if (mask[i]) s = s + 32'(val);
        e.err    = s;
        e.status = (s <= EL) ? 2'd1 : 2'd2;
        e.tries  = t;
        return e;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0 || status !== 2'd0 || err_total !== 32'd0 || tries !== 4'd0) begin
            n_fail++;
            $display("FAIL start_entry: got busy=%b done=%b status=%0d err_total=%0h tries=%0d, expected busy=1 done=0 status=0 err_total=0 tries=0",
                     busy, done, status, err_total, tries);
        end
    endtask

    // Acts as the dataExtract side: lock 3 cycles after aligner_reset falls, errors per word mask.
    task automatic run_link(input bit lock_en, input logic [15:0] err_mask, input logic [5:0] err_val,
                            input int drop_word, input int sat_word, input int start_word,
                            output int run_cycles, output int rst_pulses, output int min_rst,
                            output int max_rst, output int max_wait);
        int  lowcnt, widx, cur_rst, cyc;
        bit  dropped, in_rst, now_rst;
        lowcnt = 0; widx = 0; cur_rst = 0; cyc = 0; dropped = 0; in_rst = 0;
        run_cycles = 0; rst_pulses = 0; min_rst = 1000; max_rst = 0; max_wait = 0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done === 1'b1) break;
            now_rst = (aligner_reset === 1'b1) && (prbs_dis === 1'b0);
            if (now_rst) begin
                if (!in_rst) rst_pulses++;
                cur_rst = in_rst ? cur_rst + 1 : 1;
            end else if (in_rst) begin
                if (cur_rst < min_rst) min_rst = cur_rst;
                if (cur_rst > max_rst) max_rst = cur_rst;
            end
            in_rst = now_rst;
            if (aligner_reset === 1'b1) begin
                aligned = 1'b0; errorCount = 6'd0; lowcnt = 0; widx = 0;
            end else if (aligned) begin
                run_cycles++;
                if (sat_word >= 0 && widx == sat_word + 1) begin
                    n_tests++;
                    if (err_total !== 32'hFFFF_FFFF) begin
                        n_fail++;
                        $display("FAIL sat_clamp: got err_total=%0h, expected ffffffff", err_total);
                    end
                end
                if (start_word >= 0 && widx == start_word + 1) begin
                    n_tests++;
                    if (busy !== 1'b1 || tries !== 4'd1 || aligner_reset !== 1'b0 || done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL start_busy_ignored: got busy=%b tries=%0d aligner_reset=%b done=%b, expected 1 1 0 0",
                                 busy, tries, aligner_reset, done);
                    end
                end
                if (widx == drop_word && !dropped) begin
                    aligned = 1'b0; errorCount = 6'd63; dropped = 1;
                end else begin
                    errorCount = (widx < 16 && err_mask[widx]) ? err_val : 6'd0;
                    if (widx == sat_word) begin
                        force dut.err_total = 32'hFFFF_FFD0;
                        #1;
                        release dut.err_total;
                    end
                    if (widx == start_word) start = 1'b1;
                end
                widx++;
            end else begin
                errorCount = 6'd0;
                lowcnt++;
                if (lowcnt > max_wait) max_wait = lowcnt;
                if (lock_en && lowcnt >= 3) aligned = 1'b1;
            end
        end
        aligned = 1'b0;
        errorCount = 6'd0;
        if (done !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL link_timeout: got done=%b after %0d cycles, expected done=1", done, cyc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (prbs_dis !== 1'b1 || aligner_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            status !== 2'd0 || err_total !== 32'd0 || tries !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: got prbs_dis=%b aligner_reset=%b busy=%b done=%b status=%0d err_total=%0h tries=%0d, expected 1 1 0 0 0 0 0",
                     prbs_dis, aligner_reset, busy, done, status, err_total, tries);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_pass();
        exp_t e;
        int rc, rp, mn, mx, mw;
        gt_ready = 1'b1;
        sb.push_back(expect_run(16'h0000, 6'd0, 4'd1));
        do_start();
        run_link(1'b1, 16'h0000, 6'd0, -1, -1, -1, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL clean_result: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
        n_tests++;
        if (rc !== TW) begin
            n_fail++;
            $display("FAIL clean_run_cycles: got %0d, expected %0d", rc, TW);
        end
        n_tests++;
        if (rp !== 1 || mx !== RSTC) begin
            n_fail++;
            $display("FAIL clean_align_rst: got pulses=%0d len=%0d, expected pulses=1 len=%0d", rp, mx, RSTC);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || status !== 2'd1 || prbs_dis !== 1'b1 || aligner_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: got done=%b busy=%b status=%0d prbs_dis=%b aligner_reset=%b, expected 1 0 1 1 1",
                     done, busy, status, prbs_dis, aligner_reset);
        end
    endtask

    task automatic test_error_limit();
        exp_t e;
        int rc, rp, mn, mx, mw;
        sb.push_back(expect_run(16'h8421, 6'd1, 4'd1));
        do_start();
        run_link(1'b1, 16'h8421, 6'd1, -1, -1, -1, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL err_over_limit: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
        sb.push_back(expect_run(16'h8401, 6'd1, 4'd1));
        do_start();
        run_link(1'b1, 16'h8401, 6'd1, -1, -1, -1, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL err_at_limit: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
    endtask

    task automatic test_lock_timeout();
        exp_t e;
        int rc, rp, mn, mx, mw;
        e.status = 2'd3; e.err = 32'd0; e.tries = 4'(MT);
        sb.push_back(e);
        do_start();
        run_link(1'b0, 16'h0000, 6'd0, -1, -1, -1, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL timeout_result: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
        n_tests++;
        if (rp !== MT || mn !== RSTC || mx !== RSTC) begin
            n_fail++;
            $display("FAIL timeout_rst_pulses: got pulses=%0d min=%0d max=%0d, expected pulses=%0d len=%0d", rp, mn, mx, MT, RSTC);
        end
        n_tests++;
        if (mw !== LTO || rc !== 0) begin
            n_fail++;
            $display("FAIL timeout_wait_len: got wait=%0d run=%0d, expected wait=%0d run=0", mw, rc, LTO);
        end
    endtask

    task automatic test_lock_loss();
        exp_t e;
        int rc, rp, mn, mx, mw;
        sb.push_back(expect_run(16'h0006, 6'd1, 4'd2));
        do_start();
        run_link(1'b1, 16'h0006, 6'd1, 5, -1, -1, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL lock_loss_result: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
        n_tests++;
        if (rp !== 2 || rc !== 5 + 1 + TW) begin
            n_fail++;
            $display("FAIL lock_loss_retry: got pulses=%0d run=%0d, expected pulses=2 run=%0d", rp, rc, 6 + TW);
        end
    endtask

    task automatic test_saturation_start_busy();
        exp_t e;
        int rc, rp, mn, mx, mw;
        e.status = 2'd2; e.err = 32'hFFFF_FFFF; e.tries = 4'd1;
        sb.push_back(e);
        do_start();
        run_link(1'b1, 16'hFFFF, 6'd63, -1, 8, 3, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL sat_result: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
    endtask

    task automatic test_gt_drop();
        exp_t e;
        int rc, rp, mn, mx, mw;
        sb.push_back(expect_run(16'h0000, 6'd0, 4'd2));
        do_start();
        for (int i = 0; i < 50 && aligner_reset !== 1'b0; i++) @(negedge clk);
        n_tests++;
        if (aligner_reset !== 1'b0 || prbs_dis !== 1'b0) begin
            n_fail++;
            $display("FAIL gt_drop_reach_lock: got aligner_reset=%b prbs_dis=%b, expected 0 0", aligner_reset, prbs_dis);
        end
        @(negedge clk);
        gt_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (prbs_dis !== 1'b1 || aligner_reset !== 1'b1 || busy !== 1'b1 || tries !== 4'd1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL gt_drop_wait_gt: got prbs_dis=%b aligner_reset=%b busy=%b tries=%0d done=%b, expected 1 1 1 1 0",
                     prbs_dis, aligner_reset, busy, tries, done);
        end
        gt_ready = 1'b1;
        run_link(1'b1, 16'h0000, 6'd0, -1, -1, -1, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL gt_drop_result: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int rc, rp, mn, mx, mw;
        do_start();
        for (int i = 0; i < 50 && aligner_reset !== 1'b0; i++) @(negedge clk);
        aligned = 1'b1;
        errorCount = 6'd5;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (prbs_dis !== 1'b1 || aligner_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            status !== 2'd0 || err_total !== 32'd0 || tries !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got prbs_dis=%b aligner_reset=%b busy=%b done=%b status=%0d err_total=%0h tries=%0d, expected 1 1 0 0 0 0 0",
                     prbs_dis, aligner_reset, busy, done, status, err_total, tries);
        end
        aligned = 1'b0;
        errorCount = 6'd0;
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(expect_run(16'h0001, 6'd2, 4'd1));
        do_start();
        run_link(1'b1, 16'h0001, 6'd2, -1, -1, -1, rc, rp, mn, mx, mw);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || status !== e.status || err_total !== e.err || tries !== e.tries) begin
            n_fail++;
            $display("FAIL post_reset_result: got done=%b status=%0d err_total=%0h tries=%0d, expected done=1 status=%0d err_total=%0h tries=%0d",
                     done, status, err_total, tries, e.status, e.err, e.tries);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        gt_ready = 1'b0;
        aligned = 1'b0;
        errorCount = 6'd0;
        test_reset();
        test_clean_pass();
        test_error_limit();
        test_lock_timeout();
        test_lock_loss();
        test_saturation_start_busy();
        test_gt_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
